// File: rtl/sprite_loader.sv
// Sprite loader: unpacks two-pixel bytes from a valid/ready stream into
// row-major sprite RAM writes, accepting new bytes only during vertical blank.
module sprite_loader #(
  parameter int SPR_WIDTH  = 32,
  parameter int SPR_HEIGHT = 20,
  parameter int SPR_DATAW  = 4,
  parameter int SPR_ADDRW  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vblank,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [SPR_ADDRW-1:0] wr_addr,
  output logic [SPR_DATAW-1:0] wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int NPIX = SPR_WIDTH * SPR_HEIGHT;
  localparam logic [SPR_ADDRW-1:0] LAST_ADDR = SPR_ADDRW'(NPIX - 1);
  localparam logic [SPR_ADDRW-1:0] ADDR_ONE  = SPR_ADDRW'(1);
  localparam logic [SPR_ADDRW-1:0] ADDR_ZERO = SPR_ADDRW'(0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WR_LO  = 3'd2;
  localparam logic [2:0] S_WR_HI  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]           state_r;
  logic [2:0]           state_s;
  logic [SPR_ADDRW-1:0] cnt_r;
  logic [SPR_ADDRW-1:0] cnt_inc_s;
  logic [7:0]           byte_r;
  logic                 in_ready_s;
  logic                 handshake_s;
  logic                 wr_en_r;
  logic [SPR_ADDRW-1:0] wr_addr_r;
  logic [SPR_DATAW-1:0] wr_data_r;
  logic                 busy_r;
  logic                 done_r;

  // Low nibble is the first pixel on the stream, high nibble the second.
  function automatic logic [SPR_DATAW-1:0] pick_pixel(input logic [7:0] b, input logic hi);
    if (hi) begin
      pick_pixel = SPR_DATAW'(b[7:4]);
    end else begin
      pick_pixel = SPR_DATAW'(b[3:0]);
    end
  endfunction

  assign cnt_inc_s = cnt_r + ADDR_ONE;

  // Ready follows vblank only while waiting for a byte.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == S_ACCEPT) begin
      in_ready_s = vblank;
    end else begin
      in_ready_s = 1'b0;
    end
    handshake_s = in_valid & in_ready_s;
  end

  // Next-state decode; start outside IDLE is deliberately ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_ACCEPT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (handshake_s) begin
          state_s = S_WR_LO;
        end else begin
          state_s = S_ACCEPT;
        end
      end
      S_WR_LO: state_s = S_WR_HI;
      S_WR_HI: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = S_FINISH;
        end else begin
          state_s = S_ACCEPT;
        end
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State and status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wr_en_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_FINISH);
      wr_en_r <= (state_s == S_WR_LO) || (state_s == S_WR_HI);
    end
  end

  // Address/data are loaded one edge ahead so they are valid throughout WR_LO/WR_HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= ADDR_ZERO;
      byte_r    <= 8'h00;
      wr_addr_r <= ADDR_ZERO;
      wr_data_r <= SPR_DATAW'(0);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cnt_r <= ADDR_ZERO;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_ACCEPT: begin
          if (handshake_s) begin
            byte_r    <= in_data;
            wr_addr_r <= cnt_r;
            wr_data_r <= pick_pixel(in_data, 1'b0);
          end else begin
            byte_r    <= byte_r;
          end
        end
        S_WR_LO: begin
          cnt_r     <= cnt_inc_s;
          wr_addr_r <= cnt_inc_s;
          wr_data_r <= pick_pixel(byte_r, 1'b1);
        end
        S_WR_HI: begin
          cnt_r <= cnt_inc_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready = in_ready_s;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: the driver queues expected RAM writes at
// each handshake, a negedge monitor pops and compares every wr_en cycle.
module tb_sprite_loader;

  typedef struct packed {
    logic [9:0] addr;
    logic [3:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       vblank;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [3:0] wr_data;
  logic       busy;
  logic       done;

  int  checks;
  int  failures;
  int  done_cnt;
  int  last_addr;
  int  exp_addr;
  logic prev_done;
  wr_t exp_q[$];

  sprite_loader #(
    .SPR_WIDTH(32), .SPR_HEIGHT(20), .SPR_DATAW(4), .SPR_ADDRW(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vblank(vblank),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [7:0] b;
    b[3:0] = 4'((2 * k + 1) % 16);
    b[7:4] = 4'((2 * k + 2) % 16);
    return b;
  endfunction

  // Monitor: compare every write and watch the done/busy relationship.
  initial begin
    prev_done = 1'b0;
    done_cnt  = 0;
    last_addr = -1;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=addr %0d data %0h expected=no write", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
          last_addr = int'(wr_addr);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
        check("busy_with_done", 32'(busy), 32'd1);
      end else if (prev_done === 1'b1) begin
        check("busy_fall", 32'(busy), 32'd0);
      end
      prev_done = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one byte, wait (bounded) for acceptance, queue its two writes.
  task automatic send_byte(input logic [7:0] b, input bit lat_check);
    int waited;
    int lo;
    waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 400) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    lo = exp_addr;
    exp_q.push_back('{addr: 10'(lo), data: b[3:0]});
    exp_q.push_back('{addr: 10'(lo + 1), data: b[7:4]});
    exp_addr = exp_addr + 2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (lat_check) begin
      @(negedge clk);
      check("lat_lo_en", 32'(wr_en), 32'd1);
      check("lat_lo_addr", 32'(wr_addr), 32'(lo));
      @(negedge clk);
      check("lat_hi_en", 32'(wr_en), 32'd1);
    end
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(n));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_addr = 0;
    rst_n = 1'b0; start = 1'b0; vblank = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load 1: stall with vblank low, then 320 back-to-back bytes 0x21,0x43,...
    pulse_start();
    exp_addr = 0;
    in_valid = 1'b1;
    in_data  = 8'h21;
    repeat (4) begin
      @(negedge clk);
      check("novblank_in_ready", 32'(in_ready), 32'd0);
      check("novblank_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1 vblank = 1'b1;
    for (int k = 0; k < 320; k++) send_byte(pat(k), 1'b1);
    wait_done(1);
    check("load1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("load1_last_addr", 32'(last_addr), 32'd639);

    // Load 2: random valid gaps, vblank drop after 0xA5 at addr 100, stray start at addr 300
    @(posedge clk);
    #1;
    pulse_start();
    exp_addr = 0;
    for (int k = 0; k < 320; k++) begin
      logic [7:0] b;
      if (k == 50) b = 8'hA5;
      else if (k >= 150) b = 8'($urandom_range(0, 255));
      else b = pat(k);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (k == 50) begin
        send_byte(b, 1'b0);
        vblank   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (8) begin
          @(negedge clk);
          check("vblank_drop_in_ready", 32'(in_ready), 32'd0);
        end
        check("vblank_drop_writes_done", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1 vblank = 1'b1;
      end else if (k == 150) begin
        send_byte(b, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end else begin
        send_byte(b, 1'b1);
      end
    end
    wait_done(2);
    check("load2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("load2_last_addr", 32'(last_addr), 32'd639);

    // Load 3: reset between WR_LO and WR_HI
    @(posedge clk);
    #1;
    pulse_start();
    exp_addr = 0;
    for (int k = 0; k < 4; k++) send_byte(pat(k), 1'b1);
    send_byte(8'h7E, 1'b0);
    @(negedge clk);
    check("pre_rst_wr_en", 32'(wr_en), 32'd1);
    check("pre_rst_wr_addr", 32'(wr_addr), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    exp_addr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    vblank   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (5) begin
      @(negedge clk);
      check("postrst_in_ready", 32'(in_ready), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    pulse_start();
    send_byte(8'h9C, 1'b1);
    repeat (3) @(negedge clk);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_done_after_reset", 32'(done_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 The module SHALL have parameter SPR_WIDTH, default 32, sprite width in pixels.
REQ-002 The module SHALL have parameter SPR_HEIGHT, default 20, sprite height in lines.
REQ-003 The module SHALL have parameter SPR_DATAW, default 4, pixel width in bits (packing rules assume 4).
REQ-004 The module SHALL have parameter SPR_ADDRW, default 10, sprite RAM address width.
REQ-005 The module SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 The module SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 The module SHALL have port start  input  1  one-cycle request to begin a full sprite load.
REQ-008 The module SHALL have port vblank  input  1  high while display is in vertical blank; loading permitted only then.
REQ-009 The module SHALL have port in_data  input  8  packed byte: bits[3:0] first pixel, bits[7:4] second pixel.
REQ-010 The module SHALL have port in_valid  input  1  in_data valid.
REQ-011 The module SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-012 The module SHALL have port wr_en  output  1  sprite RAM write strobe.
REQ-013 The module SHALL have port wr_addr  output  SPR_ADDRW  sprite RAM write address, row-major (y*SPR_WIDTH + x).
REQ-014 The module SHALL have port wr_data  output  SPR_DATAW  sprite RAM write pixel.
REQ-015 The module SHALL have port busy  output  1  load in progress.
REQ-016 The module SHALL have port done  output  1  one-cycle pulse when the last pixel is written.

Function
REQ-017 The module SHALL implement states IDLE, ACCEPT, WR_LO, WR_HI, FINISH.
REQ-018 IDLE: start=1 SHALL go to ACCEPT and clear pixel counter to 0; otherwise stay.
REQ-019 ACCEPT: in_ready SHALL equal vblank; in_ready SHALL be 0 in every other state.
REQ-020 ACCEPT: handshake (in_valid & in_ready) SHALL register in_data and go to WR_LO; otherwise stay.
REQ-021 WR_LO SHALL assert wr_en for one cycle with wr_addr = counter, wr_data = byte[3:0], increment counter, go to WR_HI.
REQ-022 WR_HI SHALL assert wr_en for one cycle with wr_addr = counter, wr_data = byte[7:4], increment counter; if written address = SPR_WIDTH*SPR_HEIGHT-1 go to FINISH, else ACCEPT.
REQ-023 Latency: byte accepted at edge t SHALL produce low-nibble write at cycle t+1 and high-nibble write at t+2; max throughput one byte per 3 cycles.
REQ-024 FINISH SHALL pulse done=1 for exactly one cycle and return to IDLE.
REQ-025 busy SHALL be 1 in ACCEPT, WR_LO, WR_HI, FINISH; 0 in IDLE.
REQ-026 wr_en SHALL be 0, and wr_addr/wr_data SHALL hold last values, outside WR_LO/WR_HI.
REQ-027 vblank falling mid-byte SHALL NOT abort the pending WR_LO/WR_HI writes; only new acceptance stalls until vblank returns.
REQ-028 start while busy SHALL be ignored; counter and state unaffected.
REQ-029 Counter SHALL be SPR_ADDRW bits; total pixels (640 at defaults) SHALL be even; counter never exceeds SPR_WIDTH*SPR_HEIGHT-1 when driving wr_addr.
REQ-030 in_data presented while in_ready=0 SHALL be ignored (no capture, no write).

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, counter 0, byte register 0, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0.
REQ-032 Reset asserted mid-load SHALL abandon the load immediately with no further writes; a new start is required after release.

Verification
REQ-033 Reset release, start, vblank=1, 320 back-to-back bytes 0x21,0x43,... -> 640 writes, addr 0..639 in order, data low-then-high nibble, done pulse once, busy falls same cycle done drops.
REQ-034 vblank=0 with in_valid=1 after start -> in_ready=0, no wr_en; raise vblank -> first write addr 0 at t+1 after handshake.
REQ-035 vblank drops the cycle after accepting byte 0xA5 at address 100 -> writes addr100=5, addr101=A still occur; no further acceptance until vblank=1.
REQ-036 start pulsed at address 300 during load -> no restart; load completes at 639 with single done.
REQ-037 rst_n asserted between WR_LO and WR_HI -> outputs zero asynchronously, no WR_HI write; post-reset state IDLE, busy=0.
REQ-038 in_valid toggling randomly under vblank=1 -> every wr_data matches scoreboard of accepted bytes; no write without prior handshake.
